// File: rtl/lut_cam.sv
// Small content-addressable lookup table with a single registered response stage.
// Optional multi-hit flag is built only when LUT_CAM_MULTIHIT_EN is defined.
module lut_cam #(
    parameter int  NR_KEY     = 4,
    parameter int  KEY_WIDTH  = 4,
    parameter int  DATA_WIDTH = 8,
    localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_vld,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [KEY_WIDTH-1:0]  req_key,
    input  logic [DATA_WIDTH-1:0] req_def,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,
    output logic [IDX_W-1:0]      rsp_idx,
    output logic                  rsp_multi
);

    logic [NR_KEY-1:0]     r_vld;
    logic [KEY_WIDTH-1:0]  r_key  [NR_KEY];
    logic [DATA_WIDTH-1:0] r_data [NR_KEY];

    logic [NR_KEY-1:0]     w_wr_sel;
    logic [NR_KEY-1:0]     w_match;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_hit_idx;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_fire;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_hit;
    logic [IDX_W-1:0]      r_rsp_idx;

    // An out-of-range wr_idx decodes to no entry, so the write is dropped.
    for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
        assign w_wr_sel[g] = wr_en && (wr_idx == IDX_W'(g));
        assign w_match[g]  = r_vld[g] && (r_key[g] == req_key);
    end

    // NOTE: combinational logic uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = req_def;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit      = 1'b1;
                w_hit_idx  = IDX_W'(i);
                w_hit_data = r_data[i];
            end
        end
    end

    // A write to an entry overrides a concurrent clr of that entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (w_wr_sel[i]) begin
                    r_vld[i] <= wr_vld;
                end else if (clr) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: key/data storage is deliberately left unreset; the vld bits alone gate matching.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_KEY; i++) begin
            if (w_wr_sel[i]) begin
                r_key[i]  <= wr_key;
                r_data[i] <= wr_data;
            end
        end
    end

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_fire    = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= '0;
        end else if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_hit_data;
            r_rsp_hit   <= w_hit;
            r_rsp_idx   <= w_hit_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef LUT_CAM_MULTIHIT_EN
    logic w_multi;
    logic r_rsp_multi;

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign w_multi = |(w_match & (w_match - NR_KEY'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_multi <= 1'b0;
        end else if (w_fire) begin
            r_rsp_multi <= w_multi;
        end
    end

    assign rsp_multi = r_rsp_multi;
`else
    assign rsp_multi = 1'b0;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_idx   = r_rsp_idx;

endmodule

// File: doc/lut_cam.md
LUT_CAM -- requirements
Module: lut_cam

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (1..64).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, key width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data width in bits; IDX_W = max(1, clog2(NR_KEY)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port clr  input  1  invalidate all entries.
REQ-007 SHALL have port wr_en  input  1  write strobe.
REQ-008 SHALL have port wr_idx  input  IDX_W  entry to write.
REQ-009 SHALL have port wr_vld  input  1  valid bit written with the entry (0 = invalidate).
REQ-010 SHALL have ports wr_key  input  KEY_WIDTH and wr_data  input  DATA_WIDTH  entry contents.
REQ-011 SHALL have ports req_valid  input  1, req_ready  output  1, req_key  input  KEY_WIDTH, req_def  input  DATA_WIDTH  lookup request and default data.
REQ-012 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  DATA_WIDTH, rsp_hit  output  1, rsp_idx  output  IDX_W, rsp_multi  output  1  lookup response.

Function
REQ-013 SHALL hold NR_KEY entries {vld, key, data}; only entries with vld=1 participate in matching.
REQ-014 SHALL accept a request when req_valid && req_ready (fire).
REQ-015 SHALL drive req_ready = !rsp_valid || rsp_ready (single output register, full throughput).
REQ-016 SHALL present the response in the cycle after fire: rsp_valid=1, latency exactly 1 clock.
REQ-017 SHALL on hit set rsp_hit=1, rsp_data=data and rsp_idx of the lowest-index matching valid entry.
REQ-018 SHALL on miss set rsp_hit=0, rsp_data=req_def captured at fire, rsp_idx=0.
REQ-019 SHALL hold rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi stable while rsp_valid && !rsp_ready.
REQ-020 SHALL clear rsp_valid after rsp_valid && rsp_ready with no concurrent fire; with concurrent fire load the new response.
REQ-021 SHALL evaluate a lookup against table contents as of the fire cycle's start; a write or clr in the same cycle affects only later lookups.
REQ-022 SHALL on wr_en update entry wr_idx with {wr_vld, wr_key, wr_data} at the clock edge.
REQ-023 SHALL ignore wr_en when wr_idx >= NR_KEY (no entry modified).
REQ-024 SHALL on clr set all vld bits to 0; when clr and wr_en coincide, clr applies first and the write then takes effect (written entry ends with vld=wr_vld).
REQ-025 SHALL not alter the pending response on clr or write.

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear all entry vld bits, rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_idx=0, rsp_multi=0.
REQ-027 SHALL leave entry key/data contents unreset (don't-care while vld=0).
REQ-028 SHALL drop any in-flight response on reset; req_ready=1 from first cycle after deassertion.

Configuration
REQ-029 SHALL with macro LUT_CAM_MULTIHIT_EN defined set rsp_multi=1 when two or more valid entries match the request key, else 0.
REQ-030 SHALL without LUT_CAM_MULTIHIT_EN keep rsp_multi tied to 0 and implement no multi-hit logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, write idx2 {1,0x5,0xA7}, lookup key 0x5 def 0x00 -> next cycle rsp_valid=1, hit=1, data=0xA7, idx=2.
REQ-032 SHALL cover: lookup key 0x9 on that table, def 0x3C -> hit=0, data=0x3C, idx=0.
REQ-033 SHALL cover: entries idx1 and idx3 both key 0x5 (data 0x11/0x33) -> data=0x11, idx=1, rsp_multi=1 with macro, 0 without.
REQ-034 SHALL cover: rsp_ready=0 for 3 cycles with req_valid held -> req_ready=0, response unchanged; then back-to-back requests with rsp_ready=1 -> one response per cycle.
REQ-035 SHALL cover: same-cycle write idx0 key 0x7 and lookup 0x7 on empty table -> miss; repeat lookup next cycle -> hit idx0.
REQ-036 SHALL cover: clr with wr_en idx1 vld=1 -> only idx1 matches afterwards; rst_n pulse mid-response -> rsp_valid=0 immediately, all lookups miss.
